// File: rtl/clock_monitor.sv
// Measures high/low phase lengths and period of CLK_IN in CLOCK cycles, and flags a stopped clock.
// Optional duty-cycle check enabled by defining CLOCK_MONITOR_DUTY_CHECK_EN (adds the DUTY_ERR port).
module clock_monitor #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             CLOCK,
    input  logic             nRESET,
    input  logic             ENABLE,
    input  logic             CLK_IN,
    output logic [WIDTH-1:0] HIGH_COUNT,
    output logic [WIDTH-1:0] LOW_COUNT,
    output logic [WIDTH:0]   PERIOD,
    output logic             VALID,
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    output logic             STOPPED,
    output logic             DUTY_ERR
`else
    output logic             STOPPED
`endif
);

    // Timeout counter is sized from TIMEOUT, so TIMEOUT may exceed the phase counter range.
    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [TW-1:0]    to_q, to_d;
    logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] low_cnt_q, low_cnt_d;
    logic [WIDTH:0]   period_q, period_d;
    logic             valid_q, valid_d;
    logic             stopped_q, stopped_d;
    logic             rise, fall, any_edge;
    logic             timeout;
    logic [WIDTH:0]   sum_w;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + WIDTH'(1);
    endfunction

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    logic duty_q, duty_d;

    function automatic logic duty_bad(input logic [WIDTH-1:0] h,
                                      input logic [WIDTH-1:0] l,
                                      input logic [WIDTH:0]   p);
        logic [WIDTH-1:0] diff;
        diff = (h >= l) ? (h - l) : (l - h);
        return ({1'b0, diff} > (p >> 3));
    endfunction
`endif

    assign rise     = sync2_q & ~sync3_q;
    assign fall     = ~sync2_q & sync3_q;
    assign any_edge = rise | fall;
    assign sum_w    = {1'b0, high_q} + {1'b0, cnt_q};

    // Two synchronizer flops followed by the edge-detect history flop.
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= CLK_IN;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_q     <= '0;
            to_q       <= '0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stopped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_q     <= high_d;
            to_q       <= to_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            stopped_q  <= stopped_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_d     = high_q;
        to_d       = to_q;
        high_cnt_d = high_cnt_q;
        low_cnt_d  = low_cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        stopped_d  = stopped_q;
        timeout    = 1'b0;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        duty_d     = duty_q;
`endif
        if (!ENABLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            to_d    = '0;
        end else if (state_q == IDLE) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
            to_d    = '0;
        end else begin
            // An edge in the same cycle as the timeout takes priority.
            if (any_edge) begin
                to_d = '0;
            end else if (to_q == TO_LAST) begin
                to_d    = '0;
                timeout = 1'b1;
            end else begin
                to_d = to_q + TW'(1);
            end
            if (rise) begin
                stopped_d = 1'b0;
            end

            case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_d   = WIDTH'(1);
                        state_d = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        high_d  = cnt_q;
                        cnt_d   = WIDTH'(1);
                        state_d = MEAS_LOW;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        high_cnt_d = high_q;
                        low_cnt_d  = cnt_q;
                        period_d   = sum_w;
                        valid_d    = 1'b1;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
                        duty_d     = duty_bad(high_q, cnt_q, sum_w);
`endif
                        cnt_d      = WIDTH'(1);
                        state_d    = MEAS_HIGH;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: ;
            endcase

            if (timeout) begin
                stopped_d = 1'b1;
                state_d   = WAIT_RISE;
            end
        end
    end

`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            duty_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign DUTY_ERR = duty_q;
`endif

    assign HIGH_COUNT = high_cnt_q;
    assign LOW_COUNT  = low_cnt_q;
    assign PERIOD     = period_q;
    assign VALID      = valid_q;
    assign STOPPED    = stopped_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed self-checking bench for clock_monitor: default instance plus a WIDTH=4 saturation instance.
`timescale 1ns/1ps
module tb_clock_monitor;

    logic CLOCK = 1'b0;
    always #0.5 CLOCK = ~CLOCK;

    logic nRESET  = 1'b0;
    logic ENABLE  = 1'b0;
    logic ENABLE2 = 1'b0;
    logic CLK_IN  = 1'b0;
    logic CLK_IN2 = 1'b0;

    logic [15:0] high_cnt, low_cnt;
    logic [16:0] period;
    logic        valid, stopped;
    logic [3:0]  high_cnt2, low_cnt2;
    logic [4:0]  period2;
    logic        valid2, stopped2;
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
    logic        duty_err, duty_err2;
`endif

    int checks = 0;
    int errors = 0;

    // CLK_IN pattern generator, in whole CLOCK cycles, changing on the falling CLOCK edge.
    int      gen_on = 0, gen_hi = 5, gen_lo = 5, gen_hold0 = 0, gen_cnt = 1;
    realtime last_fall_t = 0.0;

    always @(negedge CLOCK) begin
        if (gen_on == 0) gen_cnt = 1;
        else if (gen_cnt > 1) gen_cnt = gen_cnt - 1;
        else if (CLK_IN == 1'b1) begin
            CLK_IN = 1'b0;
            gen_cnt = gen_lo;
            last_fall_t = $realtime;
        end else if (gen_hold0 == 0) begin
            CLK_IN = 1'b1;
            gen_cnt = gen_hi;
        end
    end

    clock_monitor u_dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .ENABLE(ENABLE), .CLK_IN(CLK_IN),
        .HIGH_COUNT(high_cnt), .LOW_COUNT(low_cnt), .PERIOD(period), .VALID(valid),
        .STOPPED(stopped)
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        , .DUTY_ERR(duty_err)
`endif
    );

    clock_monitor #(.WIDTH(4), .TIMEOUT(63)) u_dut4 (
        .CLOCK(CLOCK), .nRESET(nRESET), .ENABLE(ENABLE2), .CLK_IN(CLK_IN2),
        .HIGH_COUNT(high_cnt2), .LOW_COUNT(low_cnt2), .PERIOD(period2), .VALID(valid2),
        .STOPPED(stopped2)
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        , .DUTY_ERR(duty_err2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for VALID of instance 1 or 2; waited = falling edges elapsed.
    task automatic wait_valid(input string tag, input int which, input int budget, output int waited);
        logic hit;
        hit = 1'b0;
        waited = 0;
        while (!hit && waited < budget) begin
            @(negedge CLOCK);
            waited++;
            hit = (which == 1) ? valid : valid2;
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s: no VALID within %0d cycles, observed 0 expected 1", tag, budget);
        end
    endtask

    initial begin
        int      w;
        int      vcount;
        realtime ts;

        // Reset state
        repeat (2) @(negedge CLOCK);
        check("rst_high", high_cnt, 0);
        check("rst_low", low_cnt, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_stopped", stopped, 0);
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        check("rst_duty", duty_err, 0);
`endif

        // 50% duty, 10-cycle period
        @(posedge CLOCK); #0.1;
        nRESET = 1'b1; ENABLE = 1'b1; ENABLE2 = 1'b1;
        gen_hi = 5; gen_lo = 5; gen_on = 1;
        wait_valid("first_valid", 1, 40, w);
        check("first_valid_lat", w, 14);
        check("sq_high", high_cnt, 5);
        check("sq_low", low_cnt, 5);
        check("sq_period", period, 10);
        check("sq_stopped", stopped, 0);
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        check("sq_duty", duty_err, 0);
`endif
        wait_valid("sq_valid2", 1, 30, w);
        check("sq_valid_spacing", w, 10);

        // 80% duty
        @(posedge CLOCK); #0.1;
        gen_hi = 8; gen_lo = 2;
        wait_valid("skew_valid_a", 1, 30, w);
        wait_valid("skew_valid_b", 1, 30, w);
        check("skew_spacing", w, 10);
        check("skew_high", high_cnt, 8);
        check("skew_low", low_cnt, 2);
        check("skew_period", period, 10);
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        check("skew_duty", duty_err, 1);
`endif

        // Hold CLK_IN low: STOPPED 64 cycles after the detected fall (67 after CLK_IN falls)
        @(posedge CLOCK); #0.1;
        gen_hold0 = 1;
        w = 0;
        while (stopped !== 1'b1 && w < 200) begin
            @(negedge CLOCK);
            w++;
        end
        ts = $realtime - last_fall_t;
        check("stop_seen", stopped, 1);
        check("stop_delay", int'(ts), 67);
        check("stop_hold_high", high_cnt, 8);
        @(posedge CLOCK); #0.1;
        gen_hold0 = 0;
        repeat (3) @(negedge CLOCK);
        check("stop_before_rise", stopped, 1);
        @(negedge CLOCK);
        check("stop_cleared", stopped, 0);
        wait_valid("restart_valid", 1, 30, w);
        check("restart_valid_lat", w, 10);
        check("restart_high", high_cnt, 8);
        check("restart_low", low_cnt, 2);

        // Reset in the middle of a low phase
        @(posedge CLOCK); #0.1;
        gen_hi = 5; gen_lo = 5;
        wait_valid("rst_prep_a", 1, 30, w);
        wait_valid("rst_prep_b", 1, 30, w);
        check("rst_prep_high", high_cnt, 5);
        check("rst_prep_low", low_cnt, 5);
        repeat (6) @(negedge CLOCK);
        nRESET = 1'b0;
        #0.1;
        check("mid_rst_high", high_cnt, 0);
        check("mid_rst_low", low_cnt, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_valid", valid, 0);
        #0.7;
        nRESET = 1'b1;
        wait_valid("post_rst_valid", 1, 40, w);
        check("post_rst_lat", w, 14);
        check("post_rst_period", period, 10);

        // Disable during a high phase, then re-enable
        @(posedge CLOCK); #0.1;
        ENABLE = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK);
            if (valid === 1'b1) vcount++;
        end
        check("dis_no_valid", vcount, 0);
        check("dis_hold_high", high_cnt, 5);
        check("dis_hold_period", period, 10);
        @(posedge CLOCK); #0.1;
        ENABLE = 1'b1;
        wait_valid("reen_valid", 1, 40, w);
        check("reen_lat", w, 20);
        check("reen_high", high_cnt, 5);
        check("reen_low", low_cnt, 5);

        // WIDTH=4 instance: timeout beyond counter range and high-phase saturation
        repeat (70) @(negedge CLOCK);
        check("w4_stopped", stopped2, 1);
        CLK_IN2 = 1'b1;
        repeat (40) @(negedge CLOCK);
        CLK_IN2 = 1'b0;
        repeat (5) @(negedge CLOCK);
        CLK_IN2 = 1'b1;
        wait_valid("w4_valid", 2, 8, w);
        check("w4_lat", w, 3);
        check("w4_high_sat", high_cnt2, 15);
        check("w4_low", low_cnt2, 5);
        check("w4_period", period2, 20);
        check("w4_stopped_clr", stopped2, 0);
`ifdef CLOCK_MONITOR_DUTY_CHECK_EN
        check("w4_duty", duty_err2, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
